// File: rtl/pci_target_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pci_target_ctrl
// Description : PCI target front-end; decodes the address phase, claims hits
//               and sequences Devsel/Tready/Stop, RW, Offset and Beat.
//               Optional target disconnect enabled by PCI_DISCONNECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pci_target_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          ADDR_W    = 8,
  parameter int          MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Frame,
  input  logic              Iready,
  input  logic [31:0]       AD,
  input  logic [3:0]        CBE,
  output logic              Devsel,
  output logic              Tready,
  output logic              Stop,
  output logic [1:0]        RW,
  output logic [ADDR_W-1:0] Offset,
  output logic              Beat
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUSY   = 3'd1,
    S_DECODE = 3'd2,
    S_DATA   = 3'd3,
    S_TURN   = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  localparam logic [3:0]        c_cmd_rd = 4'b0110;
  localparam logic [3:0]        c_cmd_wr = 4'b0111;
  localparam logic [ADDR_W-1:0] c_step   = ADDR_W'(4);

  state_t            r_state, w_state;
  logic              r_devsel, w_devsel;
  logic              r_tready, w_tready;
  logic              r_stop, w_stop;
  logic              r_beat, w_beat;
  logic [1:0]        r_rw, w_rw;
  logic [1:0]        r_pend, w_pend;
  logic [ADDR_W-1:0] r_offset, w_offset;
  logic              w_hit;
  logic              w_xfer;

`ifdef PCI_DISCONNECT_EN
  localparam int                 c_cnt_w = $clog2(MAX_BURST + 1);
  localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(MAX_BURST);
  logic [c_cnt_w-1:0] r_cnt, w_cnt;
`endif

  assign w_hit  = (AD[31:ADDR_W] == BASE_ADDR[31:ADDR_W]) && (AD[1:0] == 2'b00);
  assign w_xfer = ~Iready & ~r_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_devsel <= 1'b1;
      r_tready <= 1'b1;
      r_stop   <= 1'b1;
      r_beat   <= 1'b0;
      r_rw     <= 2'd0;
      r_pend   <= 2'd0;
      r_offset <= '0;
`ifdef PCI_DISCONNECT_EN
      r_cnt    <= '0;
`endif
    end else begin
      r_state  <= w_state;
      r_devsel <= w_devsel;
      r_tready <= w_tready;
      r_stop   <= w_stop;
      r_beat   <= w_beat;
      r_rw     <= w_rw;
      r_pend   <= w_pend;
      r_offset <= w_offset;
`ifdef PCI_DISCONNECT_EN
      r_cnt    <= w_cnt;
`endif
    end
  end

  // Outputs are registered: each state's actions take effect at the edge leaving it.
  always_comb begin
    w_state  = r_state;
    w_devsel = r_devsel;
    w_tready = r_tready;
    w_stop   = r_stop;
    w_beat   = 1'b0;
    w_rw     = r_rw;
    w_pend   = r_pend;
    w_offset = r_offset;
`ifdef PCI_DISCONNECT_EN
    w_cnt    = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (!Frame) begin
          if (w_hit && (CBE == c_cmd_rd || CBE == c_cmd_wr)) begin
            w_state  = S_DECODE;
            w_pend   = (CBE == c_cmd_rd) ? 2'd1 : 2'd2;
            w_offset = AD[ADDR_W-1:0];
          end else begin
            w_state = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (Frame && Iready) w_state = S_IDLE;
      end
      S_DECODE: begin
        w_state  = S_DATA;
        w_devsel = 1'b0;
        w_rw     = r_pend;
        // Reads hold Tready off for one turnaround cycle.
        w_tready = (r_pend == 2'd2) ? 1'b0 : 1'b1;
`ifdef PCI_DISCONNECT_EN
        w_cnt    = '0;
`endif
      end
      S_DATA: begin
        if (w_xfer) begin
          w_beat   = 1'b1;
          w_offset = r_offset + c_step;
`ifdef PCI_DISCONNECT_EN
          w_cnt    = r_cnt + 1'b1;
          if (Frame) begin
            w_state = S_TURN;
          end else if (w_cnt == c_max) begin
            w_state  = S_STOP;
            w_stop   = 1'b0;
            w_tready = 1'b1;
          end
`else
          if (Frame) w_state = S_TURN;
`endif
        end else if (Frame && Iready) begin
          w_state = S_TURN;
        end else if (r_tready) begin
          w_tready = 1'b0;
        end
      end
      S_STOP: begin
        if (Frame) w_state = S_TURN;
      end
      S_TURN: begin
        w_state  = S_IDLE;
        w_devsel = 1'b1;
        w_tready = 1'b1;
        w_stop   = 1'b1;
        w_rw     = 2'd0;
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign Devsel = r_devsel;
  assign Tready = r_tready;
  assign Stop   = r_stop;
  assign Beat   = r_beat;
  assign RW     = r_rw;
  assign Offset = r_offset;

endmodule
`default_nettype wire

// File: doc/pci_target_ctrl.md
# pci_target_ctrl

PCI target front-end for the slave: watches the shared bus (Frame, AD, CBE, Iready) and decodes the address phase. On an address hit for a supported command it claims the transaction and drives Devsel and Tready. It produces the RW command code and the burst word offset. It feeds the downstream read/write data stage, which samples Devsel, Iready and RW on the falling clock edge.

## Interface
- BASE_ADDR, 32'h0000_1000, base of the claimed memory window; bits [31:ADDR_W] are compared.
- ADDR_W, 8, window size is 2^ADDR_W bytes; width of Offset.
- MAX_BURST, 4, data phases per transaction before target disconnect (used only with PCI_DISCONNECT_EN).

Ports:
- clk  in  1  bus clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Frame  in  1  active-low cycle frame from the initiator.
- Iready  in  1  active-low initiator ready.
- AD  in  32  address/data bus; sampled only in the address phase.
- CBE  in  4  command/byte-enable; sampled only in the address phase.
- Devsel  out  1  active-low device select, registered.
- Tready  out  1  active-low target ready, registered.
- Stop  out  1  active-low target stop, registered.
- RW  out  2  command code to the data stage: 0 none, 1 read, 2 write; 3 is never driven.
- Offset  out  ADDR_W  byte offset of the current data phase within the window.
- Beat  out  1  active-high, one-cycle pulse after each completed data phase.

## Operation
- Reset (async, immediate, also mid-transaction): state IDLE; Devsel=1, Tready=1, Stop=1, RW=0, Offset=0, Beat=0.
- IDLE: Frame==0 at an edge is the address phase.
  - Hit condition: AD[31:ADDR_W]==BASE_ADDR[31:ADDR_W] and AD[1:0]==0.
  - Hit with CBE=4'b0110 (memory read): go to DECODE, pending RW=1.
  - Hit with CBE=4'b0111 (memory write): go to DECODE, pending RW=2.
  - In both cases Offset loads AD[ADDR_W-1:0].
  - Any other command or a miss: go to BUSY.
- BUSY: outputs stay idle; return to IDLE at the first edge where Frame==1 and Iready==1.
- DECODE (medium decode, one cycle): go to DATA and drive Devsel=0 and RW=pending.
  - Write: Tready=0 at the same time.
  - Read: Tready=1 for one turnaround cycle, then 0.
- DATA: a transfer occurs at each edge where Iready==0 and Tready==0.
  - Each transfer: Beat=1 for the next cycle; Offset += 4, wrapping modulo 2^ADDR_W.
  - Transfer with Frame==1 (last phase): go to TURN.
  - Frame==1 and Iready==1 with no transfer (initiator abandoned): go to TURN.
- TURN (one cycle): Devsel=1, Tready=1, Stop=1, RW=0, Beat=0; then IDLE. Frame is not decoded in TURN.
- STOP (only with the macro): Devsel=0, Tready=1, Stop=0; hold until Frame==1 is sampled, then go to TURN.

## Timing
- Edge E0 samples the address phase. Edge E1 (DECODE→DATA) drives Devsel=0 and RW.
  - Write: first transfer possible at E2.
  - Read: Tready=0 after E2; first transfer possible at E3.
- All outputs change only on rising edges (or on reset). They are therefore stable at the downstream falling-edge sample point.
- Wait states: while Iready==1 in DATA, Offset and Tready hold and Beat=0.
- Read turnaround cycle: Iready==0 during it is not a transfer.
- Burst with Frame held low indefinitely (macro off): unbounded; Offset wraps 0xFC→0x00 for ADDR_W=8.

## Configuration
- PCI_DISCONNECT_EN defined: a beat counter counts the transfers of the current transaction.
  - When transfer number MAX_BURST completes with Frame==0, the next cycle drives Stop=0 and Tready=1 with Devsel held 0, and the state becomes STOP.
  - If Frame==1 on that same transfer, it is a normal last phase and goes to TURN; Stop is never asserted.
- PCI_DISCONNECT_EN undefined: no beat counter; Stop is constant 1; bursts are unlimited.

## Test plan
- Write hit: AD=32'h0000_1010, CBE=0110→0111 write, Frame low for 3 phases, Iready=0 → Devsel=0 after E1, RW=2, three Beat pulses, Offset 0x10→0x14→0x18→0x1C, then TURN and idle outputs.
- Read hit: AD=32'h0000_1000, CBE=0110, single phase → RW=1; Tready=1 for one cycle after Devsel=0, then 0; one Beat; RW=0 two cycles after the transfer.
- Miss/unsupported: AD=32'h0000_2000, then a hit address with CBE=0010 → Devsel, Tready and RW stay idle throughout; the next valid transaction after Frame=Iready=1 is claimed.
- Wait states: write with Iready=1 for 2 cycles mid-burst → Offset and Tready hold and Beat=0 during the waits; the transfer resumes when Iready=0.
- Disconnect (macro on, MAX_BURST=4): Frame low for 6 phases → exactly 4 Beats, then Stop=0, Tready=1, Devsel=0 until Frame=1, then TURN. With the macro off, 6 Beats and Stop=1 throughout.
- Reset mid-burst: rst_n=0 during DATA → all outputs go idle immediately without a clock edge; after release, a new address phase is decoded normally.
